// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the core front end.
//   XLEN             : address / PC width
//   NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one buffered fetch result {instr, pc, misalign}
//   align_word()     : clears the two low bits of an address
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int unsigned      XLEN             = 32;
  localparam logic [31:0]      NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched instructions between the memory response
// and decode. The head entry is read straight out of the storage registers.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_flush        : empty the FIFO this cycle (wins over push)
//   i_push         : write i_push_data at the tail
//   i_pop          : drop the head entry (ignored when empty)
//   o_valid        : head entry present
//   o_data         : head entry
//   o_count        : number of stored entries
// A push while full is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = FETCH_ENTRY_W,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; o_valid guards its contents, and
  // leaving it out of reset keeps it as plain registers without reset muxes.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush && !i_rst) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid = ~w_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues one-word reads to instruction
// memory (fixed one-cycle latency), buffers responses in fetch_fifo and hands
// them to decode over valid/ready. A redirect flushes buffered and in-flight
// instructions and refetches from the (word-aligned) target.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   o_imem_req/o_imem_addr: read request and word address
//   i_imem_rdata          : read data, one cycle after the request
//   i_redirect_valid/_pc  : flush and refetch from target
//   o_if_valid/i_if_ready : decode handshake
//   o_if_instr/o_if_pc    : head instruction and its PC
//   o_if_misalign         : head is a misaligned-target marker
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When defined, a redirect to
// a non word-aligned target produces a single NOP marker entry flagged
// misaligned and halts fetch until the next redirect or reset. When undefined
// the low target bits are dropped and o_if_misalign is constant 0.
// -----------------------------------------------------------------------------
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [31:0]     o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  output logic            o_if_misalign
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;

  logic            w_halted;
  logic            w_pop;
  logic            w_req;
  logic            w_push;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_used;
  logic            w_head_valid;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_pop = w_head_valid & i_if_ready;

  // Slots committed after this cycle: in-flight response plus stored entries,
  // minus the one decode takes now. Counting the pop lets a full FIFO keep
  // streaming at one instruction per cycle.
  assign w_used = CW'(r_inflight) + w_count - CW'(w_pop);
  assign w_req  = ~i_rst & ~i_redirect_valid & ~w_halted & (w_used < CW'(DEPTH));

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (i_redirect_valid) begin
      // The outstanding response (if any) is dropped by clearing the flag.
      r_pc       <= align_word(i_redirect_pc);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + XLEN'(4);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            r_halted;
  logic            r_marker_pending;
  logic [XLEN-1:0] r_marker_pc;
  logic            w_redirect_misaligned;

  assign w_redirect_misaligned = i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);
  assign w_halted              = r_halted;

  // The redirect cycle flushes the FIFO, so the marker is pushed one cycle
  // later; no response can be in flight then because the redirect cycle
  // never issues a request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_halted         <= 1'b0;
      r_marker_pending <= 1'b0;
    end else if (i_redirect_valid) begin
      r_halted         <= w_redirect_misaligned;
      r_marker_pending <= w_redirect_misaligned;
      r_marker_pc      <= i_redirect_pc;
    end else begin
      r_marker_pending <= 1'b0;
    end
  end

  assign w_push       = (r_inflight | r_marker_pending) & ~i_redirect_valid;
  assign w_push_entry = r_marker_pending
                      ? fetch_entry_t'{instr: NOP_INSTR, pc: r_marker_pc, misalign: 1'b1}
                      : fetch_entry_t'{instr: i_imem_rdata, pc: r_inflight_pc, misalign: 1'b0};
  assign o_if_misalign = w_head_valid & w_head.misalign;
`else
  logic w_unused_misalign;

  assign w_halted          = 1'b0;
  assign w_push            = r_inflight & ~i_redirect_valid;
  assign w_push_entry      = fetch_entry_t'{instr: i_imem_rdata, pc: r_inflight_pc, misalign: 1'b0};
  assign o_if_misalign     = 1'b0;
  assign w_unused_misalign = w_head.misalign;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_valid     (w_head_valid),
    .o_data      (w_head),
    .o_count     (w_count)
  );

  assign o_if_valid = w_head_valid;
  assign o_if_instr = w_head.instr;
  assign o_if_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit (DEPTH=2, RESET_PC=0). The memory model
// answers every request with addr ^ 32'hA5A5_0000 one cycle later. Expected
// deliveries live in a scoreboard queue refilled at each reset/redirect;
// every decode transfer pops and compares one entry. A cycle table covers
// start-up and backpressure, hand-written sequences cover redirect, reset and
// misaligned-target behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_misalign;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (imem_rdata),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_if_valid       (if_valid),
    .i_if_ready       (if_ready),
    .o_if_instr       (if_instr),
    .o_if_pc          (if_pc),
    .o_if_misalign    (if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;

  // Values sampled at the falling edge of the last cycle.
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic        s_mis;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_reset(input logic [31:0] start);
    exp_t e;
    sb_q.delete();
    for (int i = 0; i < 40; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = e.pc ^ KEY;
      e.mis   = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  // One clock cycle: sample and score at negedge, then answer the memory
  // request just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = if_valid;
    s_pc    = if_pc;
    s_mis   = if_misalign;
    if (if_valid && if_ready) begin
      n_xfer++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pc", 64'(if_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc",       64'(if_pc),       64'(e.pc));
        check("sb_instr",    64'(if_instr),    64'(e.instr));
        check("sb_misalign", 64'(if_misalign), 64'(e.mis));
      end
    end
    @(posedge clk);
    #1;
    imem_rdata = s_req ? (s_addr ^ KEY) : 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nreq;
    int nx0;
    exp_t m;

    // {if_ready, exp_req, exp_addr, exp_valid, exp_pc}, cycle 0 = first rst=0
    vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    vecs[8]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[9]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[10] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[11] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};

    rst            = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rdata     = '0;

    // Reset state
    cycle();
    cycle();
    check("rst_req",      64'(s_req),   64'd0);
    check("rst_valid",    64'(s_valid), 64'd0);
    check("rst_misalign", 64'(s_mis),   64'd0);

    // Start-up and backpressure table
    rst = 1'b0;
    sb_reset(RST_PC);
    for (int i = 0; i < 12; i++) begin
      if_ready = vecs[i].rdy;
      cycle();
      check($sformatf("vec%0d_req", i), 64'(s_req), 64'(vecs[i].req));
      if (vecs[i].req) check($sformatf("vec%0d_addr", i), 64'(s_addr), 64'(vecs[i].addr));
      check($sformatf("vec%0d_valid", i), 64'(s_valid), 64'(vecs[i].valid));
      if (vecs[i].valid) check($sformatf("vec%0d_pc", i), 64'(s_pc), 64'(vecs[i].pc));
    end

    // Redirect to 0x100 with the FIFO full
    if_ready = 1'b0;
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    check("a_redir_req", 64'(s_req),   64'd0);
    check("a_full",      64'(s_valid), 64'd1);
    redirect_valid = 1'b0;
    sb_reset(32'h100);
    if_ready = 1'b1;
    cycle();
    check("a_t1_req",   64'(s_req),   64'd1);
    check("a_t1_addr",  64'(s_addr),  64'h100);
    check("a_t1_valid", 64'(s_valid), 64'd0);
    cycle();
    check("a_t2_valid", 64'(s_valid), 64'd0);
    cycle();
    check("a_t3_valid", 64'(s_valid), 64'd1);
    check("a_t3_pc",    64'(s_pc),    64'h100);
    repeat (4) cycle();

    // Redirect in a cycle where decode pops the head, response in flight
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    cycle();
    check("b_pop_in_redirect", 64'(s_valid), 64'd1);
    redirect_valid = 1'b0;
    sb_reset(32'h300);
    cycle();
    check("b_t1_valid", 64'(s_valid), 64'd0);
    check("b_t1_req",   64'(s_req),   64'd1);
    check("b_t1_addr",  64'(s_addr),  64'h300);
    cycle();
    check("b_t2_valid", 64'(s_valid), 64'd0);
    cycle();
    check("b_t3_valid", 64'(s_valid), 64'd1);
    check("b_t3_pc",    64'(s_pc),    64'h300);
    nx0 = n_xfer;
    repeat (10) cycle();
    check("b_steady_rate", 64'(n_xfer - nx0), 64'd10);

    // Reset for one cycle mid-stream with the FIFO full
    if_ready = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check("c_rst_req", 64'(s_req), 64'd0);
    rst = 1'b0;
    sb_reset(RST_PC);
    if_ready = 1'b1;
    cycle();
    check("c_r_valid",    64'(s_valid), 64'd0);
    check("c_r_misalign", 64'(s_mis),   64'd0);
    check("c_r_req",      64'(s_req),   64'd1);
    check("c_r_addr",     64'(s_addr),  64'(RST_PC));
    cycle();
    check("c_r1_valid", 64'(s_valid), 64'd0);
    cycle();
    check("c_r2_valid", 64'(s_valid), 64'd1);
    check("c_r2_pc",    64'(s_pc),    64'(RST_PC));
    repeat (4) cycle();

    // Redirect to a misaligned target 0x102
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cycle();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    sb_q.delete();
    m.instr = 32'h0000_0013;
    m.pc    = 32'h102;
    m.mis   = 1'b1;
    sb_q.push_back(m);
    cycle();
    check("d_t1_req", 64'(s_req), 64'd0);
    cycle();
    check("d_marker_valid", 64'(s_valid), 64'd1);
    check("d_marker_pc",    64'(s_pc),    64'h102);
    check("d_marker_mis",   64'(s_mis),   64'd1);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_req) nreq++;
    end
    check("d_halted_no_req", 64'(nreq), 64'd0);
    check("d_halted_valid",  64'(s_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    sb_reset(32'h200);
    cycle();
    check("d_resume_req",  64'(s_req),  64'd1);
    check("d_resume_addr", 64'(s_addr), 64'h200);
    cycle();
    cycle();
    check("d_resume_valid", 64'(s_valid), 64'd1);
    check("d_resume_pc",    64'(s_pc),    64'h200);
`else
    m = '0;
    sb_reset(32'h100);
    cycle();
    check("d_t1_req",  64'(s_req),  64'd1);
    check("d_t1_addr", 64'(s_addr), 64'h100);
    nreq = int'(m.mis);
    cycle();
    check("d_t2_valid", 64'(s_valid), 64'd0);
    cycle();
    check("d_t3_valid", 64'(s_valid), 64'd1);
    check("d_t3_pc",    64'(s_pc),    64'h100);
    check("d_t3_mis",   64'(s_mis),   64'(nreq));
`endif
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
